// File: rtl/spi_txn_sequencer_pkg.sv
// Shared ctrl encodings and sequencer state type.
// The SPI master imports the same constants, so both sides agree on ctrl values.
package spi_pkg;

    localparam logic [31:0] CTRL_IDLE = 32'd0;
    localparam logic [31:0] CTRL_CONF = 32'd1;
    localparam logic [31:0] CTRL_TRAN = 32'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Bundle of the command stream, response stream and SPI-master-facing signals.
// The master modport is the sequencer side; the slave modport is its environment.
interface spi_txn_sequencer_if;

    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic [31:0] spi_ctrl;
    logic [31:0] spi_data_tx;
    logic [31:0] spi_data_rd;
    logic        spi_cs_n;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  cmd_valid, cmd_data, rsp_ready, spi_data_rd, spi_cs_n,
        output cmd_ready, rsp_valid, rsp_data, spi_ctrl, spi_data_tx, busy, timeout_err
    );

    modport slave (
        output cmd_valid, cmd_data, rsp_ready, spi_data_rd, spi_cs_n,
        input  cmd_ready, rsp_valid, rsp_data, spi_ctrl, spi_data_tx, busy, timeout_err
    );

endinterface

// File: rtl/spi_txn_sequencer_fifo.sv
// Single-clock show-ahead FIFO used to queue TX command words.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Sequences CONF/TRAN ctrl commands to the SPI master for each queued TX word
// and returns the word read back once cs_n shows the transfer has ended.
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int CMD_DEPTH     = 4,
    parameter int CONF_CYCLES   = 2,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_txn_sequencer_if.master  bus
);

    localparam int CNT_MAX = (CONF_CYCLES > START_TIMEOUT) ? CONF_CYCLES : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] CONF_LAST  = CNT_W'(CONF_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);

    seq_state_t       state_r;
    seq_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      spi_ctrl_r;
    logic [31:0]      spi_ctrl_s;
    logic [31:0]      spi_data_tx_r;
    logic [31:0]      rsp_data_r;
    logic             rsp_valid_r;
    logic             timeout_err_r;
    logic             timeout_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [31:0]      fifo_dout_s;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid && !fifo_full_s),
        .din   (bus.cmd_data),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_dout_s)
    );

    // Next-state decode; spi_ctrl_s is the ctrl value for the state being entered.
    always_comb begin
        state_s    = state_r;
        spi_ctrl_s = CTRL_IDLE;
        pop_s      = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // Holding off while a response is pending keeps it from being overwritten.
                if (!fifo_empty_s && !rsp_valid_r) begin
                    pop_s      = 1'b1;
                    state_s    = LOAD;
                    spi_ctrl_s = CTRL_CONF;
                end else begin
                    state_s    = IDLE;
                end
            end
            LOAD: begin
                if (cnt_r == CONF_LAST) begin
                    state_s    = START;
                    spi_ctrl_s = CTRL_TRAN;
                end else begin
                    spi_ctrl_s = CTRL_CONF;
                end
            end
            START: begin
                if (!bus.spi_cs_n) begin
                    state_s = WAIT;
                end else if (cnt_r == START_LAST) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    spi_ctrl_s = CTRL_TRAN;
                end
            end
            WAIT: begin
                // ctrl stays 0 here so the master cannot re-launch from its SET state.
                if (bus.spi_cs_n) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = WAIT;
                end
            end
            CAPTURE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, dwell counter and registered SPI-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            spi_ctrl_r    <= CTRL_IDLE;
            spi_data_tx_r <= 32'd0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= (state_s != state_r) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            spi_ctrl_r    <= spi_ctrl_s;
            timeout_err_r <= timeout_s;
            if (pop_s) begin
                spi_data_tx_r <= fifo_dout_s;
            end
        end
    end

    // Response holding register: loaded in CAPTURE, released by the consumer handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
        end else if (state_r == CAPTURE) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= bus.spi_data_rd;
        end else if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign bus.cmd_ready   = !fifo_full_s;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.spi_ctrl    = spi_ctrl_r;
    assign bus.spi_data_tx = spi_data_tx_r;
    assign bus.busy        = (state_r != IDLE) || !fifo_empty_s;
    assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Self-checking bench for spi_txn_sequencer with a behavioural SPI master/slave;
// the slave answers each word with word ^ KEY, giving the expected responses.
module tb_spi_txn_sequencer;
    import spi_pkg::*;

    localparam logic [31:0] KEY = 32'hB791_5977;

    logic clk = 1'b0;
    logic rst;
    logic no_master;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    spi_txn_sequencer_if bus();

    spi_txn_sequencer #(
        .CMD_DEPTH     (4),
        .CONF_CYCLES   (2),
        .START_TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural SPI master + loopback slave: random start delay and length.
    logic [31:0] m_tx;
    int          m_st;
    int          m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            bus.spi_cs_n    <= 1'b1;
            bus.spi_data_rd <= 32'd0;
            m_st            <= 0;
            m_cnt           <= 0;
        end else begin
            if (bus.spi_ctrl == CTRL_CONF) m_tx <= bus.spi_data_tx;
            case (m_st)
                0: if (bus.spi_ctrl == CTRL_TRAN && !no_master) begin
                       m_st  <= 1;
                       m_cnt <= $urandom_range(0, 3);
                   end
                1: if (m_cnt == 0) begin
                       bus.spi_cs_n <= 1'b0;
                       m_st         <= 2;
                       m_cnt        <= $urandom_range(2, 8);
                   end else m_cnt <= m_cnt - 1;
                2: if (m_cnt == 0) begin
                       bus.spi_cs_n    <= 1'b1;
                       bus.spi_data_rd <= m_tx ^ KEY;
                       m_st            <= 0;
                   end else m_cnt <= m_cnt - 1;
                default: m_st <= 0;
            endcase
        end
    end

    // Passive monitor: accepted responses, timeout pulses, CONF rising edges.
    logic [31:0] got_q[$];
    int          to_cnt = 0;
    int          conf_rises = 0;
    logic [31:0] prev_ctrl;
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) got_q.push_back(bus.rsp_data);
        if (bus.timeout_err === 1'b1) to_cnt <= to_cnt + 1;
        if (bus.spi_ctrl === CTRL_CONF && prev_ctrl !== CTRL_CONF) conf_rises <= conf_rises + 1;
        prev_ctrl <= bus.spi_ctrl;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, output int stalls);
        stalls = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = w;
        while (bus.cmd_ready !== 1'b1 && stalls < 5000) begin
            tick();
            stalls++;
        end
        if (stalls >= 5000) begin
            tests_run++; tests_failed++;
            $display("FAIL push_timeout: cmd_ready stuck at %b, required 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [38:0] got;
        logic [38:0] want;
        got  = {bus.cmd_ready, bus.rsp_valid, bus.busy, bus.timeout_err, bus.spi_ctrl[2:0]};
        want = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL reset_flags: got %h required %h", got, want);
        end
        tests_run++;
        if (bus.spi_ctrl !== 32'd0 || bus.spi_data_tx !== 32'd0 || bus.rsp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data: ctrl %h tx %h rsp %h, required all 0",
                     bus.spi_ctrl, bus.spi_data_tx, bus.rsp_data);
        end
    endtask

    task automatic test_single();
        logic [31:0] ctrl_t[200];
        logic        csn_t[200];
        logic        rv_t[200];
        logic [31:0] tx1;
        int st, n_conf, n_tran, idx_low, idx_high, idx_rv;
        got_q.delete();
        bus.rsp_ready = 1'b1;
        push_word(32'hA5A5_0F0F, st);
        for (int i = 0; i < 200; i++) begin
            ctrl_t[i] = bus.spi_ctrl;
            csn_t[i]  = bus.spi_cs_n;
            rv_t[i]   = bus.rsp_valid;
            if (i == 1) tx1 = bus.spi_data_tx;
            tick();
        end
        n_conf = 0; n_tran = 0; idx_low = -1; idx_high = -1; idx_rv = -1;
        for (int i = 0; i < 200; i++) begin
            if (ctrl_t[i] == CTRL_CONF) n_conf++;
            if (ctrl_t[i] == CTRL_TRAN) n_tran++;
            if (idx_low < 0 && csn_t[i] == 1'b0) idx_low = i;
            if (idx_low >= 0 && idx_high < 0 && csn_t[i] == 1'b1) idx_high = i;
            if (idx_rv < 0 && rv_t[i] == 1'b1) idx_rv = i;
        end
        tests_run++;
        if (ctrl_t[0] !== 32'd0 || ctrl_t[1] !== CTRL_CONF) begin
            tests_failed++;
            $display("FAIL single_conf_latency: ctrl %h,%h required 0,1", ctrl_t[0], ctrl_t[1]);
        end
        tests_run++;
        if (tx1 !== 32'hA5A5_0F0F) begin
            tests_failed++;
            $display("FAIL single_data_tx: got %h required a5a50f0f", tx1);
        end
        tests_run++;
        if (n_conf != 2 || ctrl_t[3] !== CTRL_TRAN) begin
            tests_failed++;
            $display("FAIL single_conf_len: %0d CONF cycles (ctrl[3]=%h), required 2 then TRAN", n_conf, ctrl_t[3]);
        end
        tests_run++;
        if (idx_low < 3 || idx_low > 197 || ctrl_t[idx_low] !== CTRL_TRAN ||
            ctrl_t[idx_low+1] !== 32'd0 || n_tran != idx_low - 2) begin
            tests_failed++;
            $display("FAIL single_tran_window: cs_n low at %0d, %0d TRAN cycles, required TRAN up to cs_n fall then 0",
                     idx_low, n_tran);
        end
        tests_run++;
        if (idx_high < 0 || idx_rv != idx_high + 2) begin
            tests_failed++;
            $display("FAIL single_rsp_latency: rsp_valid at %0d, cs_n rise at %0d, required rise+2", idx_rv, idx_high);
        end
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL single_rsp: %0d responses first %h, required 1 of 12345678",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hX);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[5];
        int st, total_stall, t;
        got_q.delete();
        bus.rsp_ready = 1'b1;
        total_stall = 0;
        for (int k = 0; k < 5; k++) begin
            words[k] = $urandom;
            push_word(words[k], st);
            total_stall += st;
        end
        tests_run++;
        if (total_stall != 0 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_fill: stalls %0d cmd_ready %b busy %b, required 0 stalls, ready 0, busy 1",
                     total_stall, bus.cmd_ready, bus.busy);
        end
        t = 0;
        while (got_q.size() < 5 && t < 2000) begin tick(); t++; end
        tests_run++;
        if (got_q.size() != 5) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d responses, required 5", got_q.size());
        end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            tests_run++;
            if (got_q[k] !== (words[k] ^ KEY)) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: got %h required %h", k, got_q[k], words[k] ^ KEY);
            end
        end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_busy_end: busy %b rsp_valid %b, required 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0, w1, d0;
        int st, t, unstable, conf0;
        got_q.delete();
        bus.rsp_ready = 1'b0;
        w0 = $urandom; w1 = $urandom;
        push_word(w0, st);
        push_word(w1, st);
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 500) begin tick(); t++; end
        d0 = bus.rsp_data;
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || d0 !== (w0 ^ KEY)) begin
            tests_failed++;
            $display("FAIL bp_first: rsp_valid %b data %h, required 1 %h", bus.rsp_valid, d0, w0 ^ KEY);
        end
        conf0 = conf_rises;
        unstable = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0) unstable++;
        end
        tests_run++;
        if (unstable != 0 || conf_rises != conf0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d unstable cycles, %0d new CONF, required 0 0", unstable, conf_rises - conf0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.spi_ctrl !== 32'd0) begin
            tests_failed++;
            $display("FAIL bp_release: rsp_valid %b ctrl %h, required 0 0", bus.rsp_valid, bus.spi_ctrl);
        end
        tick();
        tests_run++;
        if (bus.spi_ctrl !== CTRL_CONF) begin
            tests_failed++;
            $display("FAIL bp_restart: ctrl %h, required 1", bus.spi_ctrl);
        end
        t = 0;
        while (got_q.size() < 2 && t < 500) begin tick(); t++; end
        tests_run++;
        if (got_q.size() != 2 || got_q[0] !== d0 || got_q[1] !== (w1 ^ KEY)) begin
            tests_failed++;
            $display("FAIL bp_order: %0d responses, required 2 (%h, %h)", got_q.size(), d0, w1 ^ KEY);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] ctrl_t[300];
        logic        to_t[300];
        int st, i0, i1, i2, pulses, rv_seen;
        got_q.delete();
        bus.rsp_ready = 1'b1;
        no_master = 1'b1;
        push_word($urandom, st);
        push_word($urandom, st);
        rv_seen = 0;
        for (int i = 0; i < 300; i++) begin
            ctrl_t[i] = bus.spi_ctrl;
            to_t[i]   = bus.timeout_err;
            if (bus.rsp_valid === 1'b1) rv_seen++;
            tick();
        end
        no_master = 1'b0;
        i0 = -1; i1 = -1; i2 = -1; pulses = 0;
        for (int i = 0; i < 300; i++) begin
            if (i0 < 0 && ctrl_t[i] == CTRL_CONF) i0 = i;
            if (i1 < 0 && to_t[i] == 1'b1) i1 = i;
            if (to_t[i] == 1'b1) pulses++;
            if (i0 >= 0 && i2 < 0 && i > i0 + 1 && ctrl_t[i] == CTRL_CONF && ctrl_t[i-1] != CTRL_CONF) i2 = i;
        end
        tests_run++;
        if (i0 < 0 || i1 != i0 + 2 + 64) begin
            tests_failed++;
            $display("FAIL timeout_delay: pulse at %0d, LOAD at %0d, required LOAD+66", i1, i0);
        end
        tests_run++;
        if (i2 != i0 + 67 || pulses != 2) begin
            tests_failed++;
            $display("FAIL timeout_next: next CONF at %0d with %0d pulses, required %0d and 2", i2, pulses, i0 + 67);
        end
        tests_run++;
        if (rv_seen != 0 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL timeout_no_rsp: rsp_valid seen %0d cycles, required 0", rv_seen);
        end
    endtask

    task automatic test_reset_mid();
        int st, t, conf0;
        got_q.delete();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) push_word($urandom, st);
        t = 0;
        while (!(bus.spi_cs_n === 1'b0 && bus.spi_ctrl === 32'd0) && t < 200) begin tick(); t++; end
        tests_run++;
        if (t >= 200) begin
            tests_failed++;
            $display("FAIL rstmid_reach_wait: cs_n %b ctrl %h, required 0 0", bus.spi_cs_n, bus.spi_ctrl);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (bus.spi_ctrl !== 32'd0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_state: ctrl %h rsp_valid %b busy %b cmd_ready %b, required 0 0 0 1",
                     bus.spi_ctrl, bus.rsp_valid, bus.busy, bus.cmd_ready);
        end
        conf0 = conf_rises;
        repeat (60) tick();
        tests_run++;
        if (got_q.size() != 0 || conf_rises != conf0) begin
            tests_failed++;
            $display("FAIL rstmid_abandon: %0d responses %0d CONF after reset, required 0 0",
                     got_q.size(), conf_rises - conf0);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        int budget;
        got_q.delete();
        fork
            begin
                int st;
                for (int k = 0; k < 12; k++) begin
                    logic [31:0] w;
                    w = $urandom;
                    exp_q.push_back(w ^ KEY);
                    repeat ($urandom_range(0, 2)) tick();
                    push_word(w, st);
                end
            end
            begin
                budget = 0;
                while (got_q.size() < 12 && budget < 20000) begin
                    bus.rsp_ready = ($urandom_range(0, 3) == 0);
                    tick();
                    budget++;
                end
            end
        join
        bus.rsp_ready = 1'b1;
        tests_run++;
        if (got_q.size() != 12) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d responses, required 12", got_q.size());
        end
        for (int k = 0; k < 12 && k < got_q.size(); k++) begin
            tests_run++;
            if (got_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL rand_data[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        no_master     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_single();
        repeat (20) tick();
        test_back_to_back();
        repeat (20) tick();
        test_backpressure();
        repeat (20) tick();
        test_timeout();
        repeat (20) tick();
        test_reset_mid();
        repeat (20) tick();
        test_random();
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
